// File: rtl/nanorv32_ahb_pkg.sv
// Shared AHB-Lite encodings and the peripheral bridge state type for the nanorv32 bus fabric.
package nanorv32_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } bridge_state_e;

endpackage

// File: rtl/nanorv32_ahb_periph_bridge_if.sv
// AHB-Lite slave-port signal bundle for the nanorv32 peripheral bridge.
interface nanorv32_ahb_periph_bridge_if;

  logic        periph_hsel;
  logic [31:0] periph_haddr;
  logic [1:0]  periph_htrans;
  logic        periph_hwrite;
  logic [2:0]  periph_hsize;
  logic        periph_hreadyin;
  logic [31:0] periph_hwdata;
  logic [31:0] periph_hrdata;
  logic        periph_hreadyout;
  logic        periph_hresp;

  modport master (
    output periph_hsel, periph_haddr, periph_htrans, periph_hwrite,
           periph_hsize, periph_hreadyin, periph_hwdata,
    input  periph_hrdata, periph_hreadyout, periph_hresp
  );

  modport slave (
    input  periph_hsel, periph_haddr, periph_htrans, periph_hwrite,
           periph_hsize, periph_hreadyin, periph_hwdata,
    output periph_hrdata, periph_hreadyout, periph_hresp
  );

endinterface

// File: rtl/nanorv32_ahb_bytesel.sv
// Byte-lane decode from AHB hsize and low address bits, with an alignment/size legality flag.
module nanorv32_ahb_bytesel
  import nanorv32_ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] bytesel,
  output logic       legal
);

  always_comb begin
    bytesel = 4'b0000;
    legal   = 1'b0;
    case (hsize)
      HSIZE_BYTE: begin
        legal   = 1'b1;
        bytesel = 4'b0001 << addr_lo;
      end
      HSIZE_HALF: begin
        legal = ~addr_lo[0];
        if (legal) bytesel = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      HSIZE_WORD: begin
        legal = (addr_lo == 2'b00);
        if (legal) bytesel = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/nanorv32_ahb_periph_bridge.sv
// AHB-Lite slave bridging onto NUM_PERIPH enable/ready peripheral channels.
// Optional wait-state timeout enabled by defining NANORV32_PERIPH_TIMEOUT_EN.
module nanorv32_ahb_periph_bridge
  import nanorv32_ahb_pkg::*;
#(
  parameter int NUM_PERIPH     = 4,
  parameter int PERIPH_ADDR_W  = 12,
  parameter int SEL_W          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk_in,
  input  logic                       rst,
  nanorv32_ahb_periph_bridge_if.slave ahb,
  output logic [PERIPH_ADDR_W-1:0]   bus_addr,
  output logic [3:0]                 bus_bytesel,
  output logic                       bus_wr,
  output logic [31:0]                bus_din,
  output logic [NUM_PERIPH-1:0]      bus_en,
  input  logic [NUM_PERIPH*32-1:0]   bus_dout,
  input  logic [NUM_PERIPH-1:0]      bus_ready
);

  localparam logic [SEL_W:0] NUM_CH_W = (SEL_W+1)'(NUM_PERIPH);

  bridge_state_e              state_reg;
  logic [PERIPH_ADDR_W-1:0]   addr_reg;
  logic [3:0]                 bytesel_reg;
  logic                       wr_reg;
  logic [SEL_W-1:0]           ch_reg;
  logic [NUM_PERIPH-1:0]      bus_en_reg;

  logic                       accept;
  logic                       accept_go;
  logic                       acc_legal;
  logic                       size_legal;
  logic [3:0]                 acc_bytesel;
  logic [SEL_W-1:0]           acc_ch;
  logic [NUM_PERIPH-1:0]      acc_onehot;
  logic [31:0]                dout_word [NUM_PERIPH];
  logic [31:0]                sel_dout;
  logic                       sel_ready;
  logic                       unused_bits;

  assign accept = ahb.periph_hsel & ahb.periph_hreadyin & ahb.periph_htrans[1];
  assign acc_ch = ahb.periph_haddr[PERIPH_ADDR_W +: SEL_W];

  nanorv32_ahb_bytesel u_bytesel (
    .hsize   (ahb.periph_hsize),
    .addr_lo (ahb.periph_haddr[1:0]),
    .bytesel (acc_bytesel),
    .legal   (size_legal)
  );

  assign acc_legal = size_legal & ({1'b0, acc_ch} < NUM_CH_W);

  generate
    for (genvar gi = 0; gi < NUM_PERIPH; gi++) begin : g_chan
      assign dout_word[gi]  = bus_dout[32*gi +: 32];
      assign acc_onehot[gi] = (acc_ch == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    sel_dout  = 32'h0;
    sel_ready = 1'b0;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      if (ch_reg == SEL_W'(i)) begin
        sel_dout  = dout_word[i];
        sel_ready = bus_ready[i];
      end
    end
  end

  // A new address phase is taken when idle, after an error, or in the ready cycle of an access.
  always_comb begin
    accept_go = 1'b0;
    case (state_reg)
      ST_IDLE, ST_ERR2: accept_go = accept;
      ST_ACCESS:        accept_go = accept & sel_ready;
      default:          accept_go = 1'b0;
    endcase
  end

`ifdef NANORV32_PERIPH_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TO_W-1:0] wait_cnt_reg;
`endif

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      bytesel_reg <= '0;
      wr_reg      <= 1'b0;
      ch_reg      <= '0;
      bus_en_reg  <= '0;
`ifdef NANORV32_PERIPH_TIMEOUT_EN
      wait_cnt_reg <= '0;
`endif
    end else if (accept_go) begin
      if (acc_legal) begin
        state_reg   <= ST_ACCESS;
        addr_reg    <= ahb.periph_haddr[PERIPH_ADDR_W-1:0];
        bytesel_reg <= acc_bytesel;
        wr_reg      <= ahb.periph_hwrite;
        ch_reg      <= acc_ch;
        bus_en_reg  <= acc_onehot;
`ifdef NANORV32_PERIPH_TIMEOUT_EN
        wait_cnt_reg <= '0;
`endif
      end else begin
        state_reg  <= ST_ERR1;
        bus_en_reg <= '0;
      end
    end else begin
      case (state_reg)
        ST_ACCESS: begin
          if (sel_ready) begin
            state_reg  <= ST_IDLE;
            bus_en_reg <= '0;
          end
`ifdef NANORV32_PERIPH_TIMEOUT_EN
          else if (wait_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_reg  <= ST_ERR1;
            bus_en_reg <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + TO_W'(1);
          end
`endif
        end
        ST_ERR1: state_reg <= ST_ERR2;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ahb.periph_hrdata    = 32'h0;
    ahb.periph_hreadyout = 1'b1;
    ahb.periph_hresp     = HRESP_OKAY;
    case (state_reg)
      ST_ACCESS: begin
        ahb.periph_hrdata    = sel_dout;
        ahb.periph_hreadyout = sel_ready;
      end
      ST_ERR1: begin
        ahb.periph_hreadyout = 1'b0;
        ahb.periph_hresp     = HRESP_ERROR;
      end
      ST_ERR2: ahb.periph_hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  assign bus_addr    = addr_reg;
  assign bus_bytesel = bytesel_reg;
  assign bus_wr      = wr_reg;
  assign bus_din     = ahb.periph_hwdata;
  assign bus_en      = bus_en_reg;

  // Address bits above the channel selector and htrans[0] play no part in decode.
  assign unused_bits = ^{ahb.periph_haddr[31:PERIPH_ADDR_W+SEL_W], ahb.periph_htrans[0]};

endmodule

// File: tb/tb_nanorv32_ahb_periph_bridge.sv
// Directed table-driven bench for nanorv32_ahb_periph_bridge plus multi-cycle corner sequences.
module tb_nanorv32_ahb_periph_bridge;
  import nanorv32_ahb_pkg::*;

  localparam int NP = 4;

  logic            clk;
  logic            rst;
  logic [11:0]     bus_addr;
  logic [3:0]      bus_bytesel;
  logic            bus_wr;
  logic [31:0]     bus_din;
  logic [NP-1:0]   bus_en;
  logic [NP*32-1:0] bus_dout;
  logic [NP-1:0]   bus_ready;

  int n_checks = 0;
  int n_fail   = 0;

  nanorv32_ahb_periph_bridge_if ahb_if ();
  assign ahb_if.periph_hreadyin = ahb_if.periph_hreadyout;

  nanorv32_ahb_periph_bridge #(
    .NUM_PERIPH     (NP),
    .PERIPH_ADDR_W  (12),
    .SEL_W          (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_in      (clk),
    .rst         (rst),
    .ahb         (ahb_if.slave),
    .bus_addr    (bus_addr),
    .bus_bytesel (bus_bytesel),
    .bus_wr      (bus_wr),
    .bus_din     (bus_din),
    .bus_en      (bus_en),
    .bus_dout    (bus_dout),
    .bus_ready   (bus_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] wdata;
    logic        err;
    logic [3:0]  exp_en;
    logic [11:0] exp_addr;
    logic [3:0]  exp_bytesel;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_addr(input logic [31:0] a, input logic [2:0] s, input logic w);
    ahb_if.periph_hsel   = 1'b1;
    ahb_if.periph_htrans = HTRANS_NONSEQ;
    ahb_if.periph_haddr  = a;
    ahb_if.periph_hsize  = s;
    ahb_if.periph_hwrite = w;
  endtask

  task automatic drive_idle();
    ahb_if.periph_hsel   = 1'b0;
    ahb_if.periph_htrans = HTRANS_IDLE;
    ahb_if.periph_haddr  = 32'h0;
    ahb_if.periph_hsize  = HSIZE_BYTE;
    ahb_if.periph_hwrite = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_idle_rdy"}, 32'(ahb_if.periph_hreadyout), 32'd1);
    chk({tag, "_idle_resp"}, 32'(ahb_if.periph_hresp), 32'd0);
    chk({tag, "_idle_en"}, 32'(bus_en), 32'd0);
    chk({tag, "_idle_rdata"}, ahb_if.periph_hrdata, 32'h0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    drive_addr(v.addr, v.size, v.wr);
    tick();
    drive_idle();
    ahb_if.periph_hwdata = v.wdata;
    @(negedge clk);
    if (!v.err) begin
      chk("vec_en", 32'(bus_en), 32'(v.exp_en));
      chk("vec_addr", 32'(bus_addr), 32'(v.exp_addr));
      chk("vec_bytesel", 32'(bus_bytesel), 32'(v.exp_bytesel));
      chk("vec_wr", 32'(bus_wr), 32'(v.wr));
      chk("vec_rdy", 32'(ahb_if.periph_hreadyout), 32'd1);
      chk("vec_resp", 32'(ahb_if.periph_hresp), 32'd0);
      chk("vec_rdata", ahb_if.periph_hrdata, v.exp_rdata);
      chk("vec_din", bus_din, v.wdata);
    end else begin
      chk("vec_err1_resp", 32'(ahb_if.periph_hresp), 32'd1);
      chk("vec_err1_rdy", 32'(ahb_if.periph_hreadyout), 32'd0);
      chk("vec_err1_en", 32'(bus_en), 32'd0);
      tick();
      @(negedge clk);
      chk("vec_err2_resp", 32'(ahb_if.periph_hresp), 32'd1);
      chk("vec_err2_rdy", 32'(ahb_if.periph_hreadyout), 32'd1);
      chk("vec_err2_en", 32'(bus_en), 32'd0);
    end
    tick();
    @(negedge clk);
    chk_idle("vec");
    tick();
    $display("vec %0d: addr=%h size=%0d wr=%0d err=%0d done", idx, v.addr, v.size, v.wr, v.err);
  endtask

  initial begin
    int  waits;
    bit  done;

    vecs[0]  = '{32'h0000_1004, HSIZE_WORD, 1'b1, 32'hCAFE_0001, 1'b0, 4'b0010, 12'h004, 4'b1111, 32'h1111_1111};
    vecs[1]  = '{32'h0000_0003, HSIZE_BYTE, 1'b0, 32'h0,         1'b0, 4'b0001, 12'h003, 4'b1000, 32'hA500_0000};
    vecs[2]  = '{32'h0000_2002, HSIZE_HALF, 1'b1, 32'h1234_5678, 1'b0, 4'b0100, 12'h002, 4'b1100, 32'h2222_2222};
    vecs[3]  = '{32'h0000_3FFC, HSIZE_HALF, 1'b0, 32'h0,         1'b0, 4'b1000, 12'hFFC, 4'b0011, 32'h3333_3333};
    vecs[4]  = '{32'h0000_0001, HSIZE_BYTE, 1'b1, 32'h0000_5A00, 1'b0, 4'b0001, 12'h001, 4'b0010, 32'hA500_0000};
    vecs[5]  = '{32'h0000_2FF2, HSIZE_BYTE, 1'b0, 32'h0,         1'b0, 4'b0100, 12'hFF2, 4'b0100, 32'h2222_2222};
    vecs[6]  = '{32'hFFFF_3008, HSIZE_WORD, 1'b0, 32'h0,         1'b0, 4'b1000, 12'h008, 4'b1111, 32'h3333_3333};
    vecs[7]  = '{32'h0000_0002, HSIZE_WORD, 1'b0, 32'h0,         1'b1, 4'b0000, 12'h000, 4'b0000, 32'h0};
    vecs[8]  = '{32'h0000_1001, HSIZE_HALF, 1'b1, 32'h0,         1'b1, 4'b0000, 12'h000, 4'b0000, 32'h0};
    vecs[9]  = '{32'h0000_0000, 3'd3,       1'b0, 32'h0,         1'b1, 4'b0000, 12'h000, 4'b0000, 32'h0};
    vecs[10] = '{32'h0000_5000, HSIZE_WORD, 1'b0, 32'h0,         1'b1, 4'b0000, 12'h000, 4'b0000, 32'h0};
    vecs[11] = '{32'h0000_4000, HSIZE_BYTE, 1'b1, 32'h0,         1'b1, 4'b0000, 12'h000, 4'b0000, 32'h0};
    vecs[12] = '{32'h0000_F000, HSIZE_BYTE, 1'b0, 32'h0,         1'b1, 4'b0000, 12'h000, 4'b0000, 32'h0};

    bus_dout  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hA500_0000};
    bus_ready = '1;
    ahb_if.periph_hwdata = 32'h0;
    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    chk("reset_addr", 32'(bus_addr), 32'd0);
    chk("reset_bytesel", 32'(bus_bytesel), 32'd0);
    chk("reset_wr", 32'(bus_wr), 32'd0);
    tick();
    rst = 1'b0;
    $display("reset released");

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // hsel low and BUSY transfers must not start an access
    ahb_if.periph_hsel = 1'b0;
    ahb_if.periph_htrans = HTRANS_NONSEQ;
    ahb_if.periph_haddr = 32'h1000;
    ahb_if.periph_hsize = HSIZE_WORD;
    tick();
    drive_idle();
    @(negedge clk);
    chk_idle("nosel");
    tick();
    ahb_if.periph_hsel = 1'b1;
    ahb_if.periph_htrans = HTRANS_BUSY;
    ahb_if.periph_haddr = 32'h1000;
    ahb_if.periph_hsize = HSIZE_WORD;
    tick();
    drive_idle();
    @(negedge clk);
    chk_idle("busy");
    tick();
    $display("seq nosel/busy done");

    // byte read with three wait states
    bus_ready[0] = 1'b0;
    drive_addr(32'h0000_0003, HSIZE_BYTE, 1'b0);
    tick();
    drive_idle();
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (ahb_if.periph_hreadyout) begin
        done = 1'b1;
        chk("wait_rdata", ahb_if.periph_hrdata, 32'hA500_0000);
        chk("wait_en", 32'(bus_en), 32'b0001);
        chk("wait_bytesel", 32'(bus_bytesel), 32'b1000);
      end else begin
        waits++;
        tick();
        if (waits == 3) bus_ready[0] = 1'b1;
      end
    end
    chk("wait_done", 32'(done), 32'd1);
    chk("wait_count", 32'(waits), 32'd3);
    tick();
    $display("seq wait-state read done, waits=%0d", waits);

    // back-to-back NONSEQ writes, channel 0 then channel 2
    drive_addr(32'h0000_0010, HSIZE_WORD, 1'b1);
    tick();
    drive_addr(32'h0000_2020, HSIZE_WORD, 1'b1);
    ahb_if.periph_hwdata = 32'hD0D0_0000;
    @(negedge clk);
    chk("b2b_en0", 32'(bus_en), 32'b0001);
    chk("b2b_addr0", 32'(bus_addr), 32'h010);
    chk("b2b_din0", bus_din, 32'hD0D0_0000);
    chk("b2b_rdy0", 32'(ahb_if.periph_hreadyout), 32'd1);
    tick();
    drive_idle();
    ahb_if.periph_hwdata = 32'hD0D0_0001;
    @(negedge clk);
    chk("b2b_en1", 32'(bus_en), 32'b0100);
    chk("b2b_addr1", 32'(bus_addr), 32'h020);
    chk("b2b_din1", bus_din, 32'hD0D0_0001);
    chk("b2b_rdy1", 32'(ahb_if.periph_hreadyout), 32'd1);
    tick();
    @(negedge clk);
    chk_idle("b2b");
    tick();
    $display("seq back-to-back done");

    // misaligned word then unmapped channel, second accepted during ERR2
    drive_addr(32'h0000_0002, HSIZE_WORD, 1'b0);
    tick();
    drive_idle();
    @(negedge clk);
    chk("perr_a1_resp", 32'(ahb_if.periph_hresp), 32'd1);
    chk("perr_a1_rdy", 32'(ahb_if.periph_hreadyout), 32'd0);
    tick();
    drive_addr(32'h0000_5000, HSIZE_WORD, 1'b0);
    @(negedge clk);
    chk("perr_a2_resp", 32'(ahb_if.periph_hresp), 32'd1);
    chk("perr_a2_rdy", 32'(ahb_if.periph_hreadyout), 32'd1);
    tick();
    drive_idle();
    @(negedge clk);
    chk("perr_b1_resp", 32'(ahb_if.periph_hresp), 32'd1);
    chk("perr_b1_rdy", 32'(ahb_if.periph_hreadyout), 32'd0);
    chk("perr_b1_en", 32'(bus_en), 32'd0);
    tick();
    @(negedge clk);
    chk("perr_b2_resp", 32'(ahb_if.periph_hresp), 32'd1);
    chk("perr_b2_rdy", 32'(ahb_if.periph_hreadyout), 32'd1);
    tick();
    @(negedge clk);
    chk_idle("perr");
    tick();
    $display("seq pipelined errors done");

    // reset during the second wait state, then a fresh read
    bus_ready[1] = 1'b0;
    drive_addr(32'h0000_1000, HSIZE_WORD, 1'b0);
    tick();
    drive_idle();
    @(negedge clk);
    chk("rst_w1_en", 32'(bus_en), 32'b0010);
    chk("rst_w1_rdy", 32'(ahb_if.periph_hreadyout), 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_w2_en", 32'(bus_en), 32'b0010);
    tick();
    rst = 1'b0;
    bus_ready[1] = 1'b1;
    @(negedge clk);
    chk_idle("rst");
    drive_addr(32'h0000_1000, HSIZE_WORD, 1'b0);
    tick();
    drive_idle();
    @(negedge clk);
    chk("rst_new_en", 32'(bus_en), 32'b0010);
    chk("rst_new_rdy", 32'(ahb_if.periph_hreadyout), 32'd1);
    chk("rst_new_rdata", ahb_if.periph_hrdata, 32'h1111_1111);
    tick();
    @(negedge clk);
    chk_idle("rst_new");
    tick();
    $display("seq reset mid-transfer done");

    // ready held low on channel 3
    bus_ready[3] = 1'b0;
    drive_addr(32'h0000_3000, HSIZE_WORD, 1'b0);
    tick();
    drive_idle();
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 120 && !done; i++) begin
      @(negedge clk);
      if (!ahb_if.periph_hreadyout && !ahb_if.periph_hresp) begin
        waits++;
        tick();
      end else begin
        done = 1'b1;
      end
    end
`ifdef NANORV32_PERIPH_TIMEOUT_EN
    chk("to_waits", 32'(waits), 32'd16);
    chk("to_err1_resp", 32'(ahb_if.periph_hresp), 32'd1);
    chk("to_err1_rdy", 32'(ahb_if.periph_hreadyout), 32'd0);
    chk("to_err1_en", 32'(bus_en), 32'd0);
    tick();
    @(negedge clk);
    chk("to_err2_resp", 32'(ahb_if.periph_hresp), 32'd1);
    chk("to_err2_rdy", 32'(ahb_if.periph_hreadyout), 32'd1);
    tick();
`else
    chk("noto_done", 32'(done), 32'd0);
    chk("noto_waits", 32'(waits), 32'd120);
    chk("noto_en", 32'(bus_en), 32'b1000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif
    bus_ready[3] = 1'b1;
    @(negedge clk);
    chk_idle("to");
    tick();
    $display("seq ready-low hold done, waits=%0d", waits);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
